// File: rtl/adc_sample_decimator_if.sv
// Signal bundle for the ADC sample decimator: measurement input stream, averaged-sample
// output stream with valid/ready handshake, and FIFO status.
interface adc_sample_decimator_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic                  enable;
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [LevelW-1:0]     fifo_level;
  logic [15:0]           dropped_count;

  // Environment side: ADC core producer plus RAM-controller consumer.
  modport master (
    output enable, adc_valid, adc_data, out_ready,
    input  out_valid, out_data, fifo_level, dropped_count
  );

  // Decimator side.
  modport slave (
    input  enable, adc_valid, adc_data, out_ready,
    output out_valid, out_data, fifo_level, dropped_count
  );
endinterface

// File: rtl/adc_sample_decimator.sv
// Averages blocks of 2^LOG2_DECIM ADC measurements and buffers the averages in a small FIFO
// with a valid/ready output; averages arriving at a full FIFO are counted and dropped.
module adc_sample_decimator #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   CLOCK,
  input logic                   RESET,
  adc_sample_decimator_if.slave bus
);
  localparam int unsigned AccW   = DATA_WIDTH + LOG2_DECIM;
  localparam int unsigned CntW   = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << LOG2_DECIM) - 1);

  logic [AccW-1:0]       acc_q, acc_d, sum;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic                  pend_q, pend_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LevelW-1:0]     level_q, level_d;
  logic [15:0]           drop_q, drop_d;

  logic full, empty, push, pop, drop;

  // Accumulation and averaging.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    avg_d  = avg_q;
    pend_d = 1'b0;  // a pending average is always consumed (pushed or dropped) next edge
    sum    = acc_q + AccW'(bus.adc_data);
    if (!bus.enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.adc_valid) begin
      if (cnt_q == LastCnt) begin
        avg_d  = DATA_WIDTH'(sum >> LOG2_DECIM);
        pend_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Output FIFO control.
  always_comb begin
    full    = (level_q == LevelW'(FIFO_DEPTH));
    empty   = (level_q == '0);
    pop     = !empty && bus.out_ready;
    push    = pend_q && (!full || pop);
    drop    = pend_q && full && !pop;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    drop_d  = drop_q;
    if (push) wr_d = wr_q + PtrW'(1);
    if (pop)  rd_d = rd_q + PtrW'(1);
    if (push && !pop) level_d = level_q + LevelW'(1);
    if (pop && !push) level_d = level_q - LevelW'(1);
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      pend_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge CLOCK) begin
    if (!RESET && push) mem_q[wr_q] <= avg_q;
  end

  assign bus.out_valid     = !empty;
  assign bus.out_data      = empty ? '0 : mem_q[rd_q];
  assign bus.fifo_level    = level_q;
  assign bus.dropped_count = drop_q;
endmodule

// File: tb/tb_adc_sample_decimator.sv
// Bench for adc_sample_decimator: directed scenarios plus a randomized run checked against a
// queue-based reference model of the averaging and buffering behaviour.
module tb_adc_sample_decimator;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_sample_decimator_if #(.DATA_WIDTH(12), .FIFO_DEPTH(4)) bus ();
  adc_sample_decimator_if #(.DATA_WIDTH(12), .FIFO_DEPTH(4)) bus0 ();

  adc_sample_decimator #(.DATA_WIDTH(12), .LOG2_DECIM(2), .FIFO_DEPTH(4)) dut (
    .CLOCK(clk), .RESET(rst), .bus(bus)
  );
  adc_sample_decimator #(.DATA_WIDTH(12), .LOG2_DECIM(0), .FIFO_DEPTH(4)) dut0 (
    .CLOCK(clk), .RESET(rst), .bus(bus0)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_blk[$];
  int m_mq[$];
  bit m_pend;
  int m_pend_val;
  int m_drops;
  int got[$];  // values the consumer actually took from the main DUT

  // Drive one cycle on the main DUT and advance the model across the edge.
  task automatic step(input bit r, input bit en, input bit v, input int d, input bit rdy);
    int sum;
    rst = r;
    bus.enable = en;
    bus.adc_valid = v;
    bus.adc_data = 12'(d);
    bus.out_ready = rdy;
    if (!r && bus.out_valid && rdy) got.push_back(int'(bus.out_data));
    @(posedge clk);
    if (r) begin
      m_blk.delete();
      m_mq.delete();
      m_pend = 1'b0;
      m_drops = 0;
    end else begin
      if (m_mq.size() > 0 && rdy) m_mq.delete(0);
      if (m_pend) begin
        if (m_mq.size() < DEPTH) m_mq.push_back(m_pend_val);
        else if (m_drops < 65535) m_drops++;
      end
      m_pend = 1'b0;
      if (!en) m_blk.delete();
      else if (v) begin
        m_blk.push_back(d);
        if (m_blk.size() == N) begin
          sum = 0;
          foreach (m_blk[i]) sum += m_blk[i];
          m_pend_val = sum / N;
          m_pend = 1'b1;
          m_blk.delete();
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    got.delete();
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    total++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 12'd0) begin bad++;
      $display("FAIL reset_data got=%0d want=0", bus.out_data); end
    total++; if (bus.fifo_level !== 3'd0) begin bad++;
      $display("FAIL reset_level got=%0d want=0", bus.fifo_level); end
    total++; if (bus.dropped_count !== 16'd0) begin bad++;
      $display("FAIL reset_dropped got=%0d want=0", bus.dropped_count); end
  endtask

  task automatic test_average();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 100 + k, 1);
      if (k < 3) begin
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
      end
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL avg_early_valid got=%b want=0", bus.out_valid); end
    step(0, 1, 0, 0, 1);
    total++; if (bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL avg_latency_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 12'd101) begin bad++;
      $display("FAIL avg_data got=%0d want=101", bus.out_data); end
    step(0, 1, 0, 0, 1);
    total++; if (bus.fifo_level !== 3'd0) begin bad++;
      $display("FAIL avg_level_drain got=%0d want=0", bus.fifo_level); end
    total++; if (got.size() != 1) begin bad++;
      $display("FAIL avg_count got=%0d want=1", got.size()); end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 1, 1, 4095, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1);
    total++; if (got.size() != 2) begin bad++;
      $display("FAIL ext_count got=%0d want=2", got.size()); end
    else begin
      total++; if (got[0] != 4095) begin bad++;
        $display("FAIL ext_max got=%0d want=4095", got[0]); end
      total++; if (got[1] != 0) begin bad++;
        $display("FAIL ext_zero got=%0d want=0", got[1]); end
    end
  endtask

  task automatic test_overflow();
    int want[$];
    do_reset();
    for (int b = 1; b <= 5; b++)
      for (int k = 0; k < 4; k++) step(0, 1, 1, b * 10, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    total++; if (bus.fifo_level !== 3'd4) begin bad++;
      $display("FAIL ovf_level got=%0d want=4", bus.fifo_level); end
    total++; if (bus.dropped_count !== 16'd1) begin bad++;
      $display("FAIL ovf_dropped got=%0d want=1", bus.dropped_count); end
    total++; if (bus.out_data !== 12'd10) begin bad++;
      $display("FAIL ovf_hold got=%0d want=10", bus.out_data); end
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 1);
    want = '{10, 20, 30, 40};
    total++; if (got != want) begin bad++;
      $display("FAIL ovf_order got_n=%0d first=%0d want=10,20,30,40", got.size(),
               (got.size() > 0) ? got[0] : -1); end
    total++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL ovf_empty got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_full_push_pop();
    int want[$];
    do_reset();
    for (int b = 6; b <= 10; b++)
      for (int k = 0; k < 4; k++) step(0, 1, 1, b * 10, 0);
    step(0, 1, 0, 0, 1);
    total++; if (bus.fifo_level !== 3'd4) begin bad++;
      $display("FAIL fpp_level got=%0d want=4", bus.fifo_level); end
    total++; if (bus.dropped_count !== 16'd0) begin bad++;
      $display("FAIL fpp_dropped got=%0d want=0", bus.dropped_count); end
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 1);
    want = '{60, 70, 80, 90, 100};
    total++; if (got != want) begin bad++;
      $display("FAIL fpp_order got_n=%0d want=60,70,80,90,100", got.size()); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    step(0, 1, 1, 1000, 1);
    step(0, 1, 1, 1000, 1);
    step(0, 0, 1, 1000, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 8, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1);
    total++; if (got.size() != 1 || got[0] != 8) begin bad++;
      $display("FAIL en_discard got_n=%0d first=%0d want=1 item 8", got.size(),
               (got.size() > 0) ? got[0] : -1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int b = 1; b <= 3; b++)
      for (int k = 0; k < 4; k++) step(0, 1, 1, b * 11, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 500, 0);
    step(0, 1, 1, 500, 0);
    total++; if (bus.fifo_level !== 3'd3) begin bad++;
      $display("FAIL rmid_pre_level got=%0d want=3", bus.fifo_level); end
    step(1, 1, 0, 0, 0);
    total++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0 || bus.out_data !== 12'd0) begin
      bad++;
      $display("FAIL rmid_cleared valid=%b level=%0d data=%0d want 0/0/0", bus.out_valid,
               bus.fifo_level, bus.out_data); end
    total++; if (bus.dropped_count !== 16'd0) begin bad++;
      $display("FAIL rmid_dropped got=%0d want=0", bus.dropped_count); end
    got.delete();
    for (int k = 0; k < 4; k++) step(0, 1, 1, 7, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1);
    total++; if (got.size() != 1 || got[0] != 7) begin bad++;
      $display("FAIL rmid_after got_n=%0d first=%0d want=1 item 7", got.size(),
               (got.size() > 0) ? got[0] : -1); end
  endtask

  // Pass-through instance: one new average every cycle must flow straight through.
  task automatic test_back_to_back();
    int d[$];
    logic [11:0] v, exp_d;
    do_reset();
    bus0.enable = 1'b1;
    bus0.adc_valid = 1'b1;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = 12'($urandom);
      d.push_back(int'(v));
      bus0.adc_data = v;
      @(posedge clk);
      #1;
      if (i >= 1) begin
        exp_d = 12'(d[i-1]);
        total++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== exp_d) begin bad++;
          $display("FAIL b2b_data i=%0d valid=%b got=%0d want=%0d", i, bus0.out_valid,
                   bus0.out_data, exp_d); end
        total++; if (bus0.fifo_level !== 3'd1) begin bad++;
          $display("FAIL b2b_level i=%0d got=%0d want=1", i, bus0.fifo_level); end
      end
    end
    bus0.enable = 1'b0;
    bus0.adc_valid = 1'b0;
    bus0.out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit en, v, rdy;
    int exp_d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 15) != 0);
      v   = ($urandom_range(0, 2) != 0);
      rdy = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(0, en, v, int'($urandom_range(0, 4095)), rdy);
      exp_d = (m_mq.size() > 0) ? m_mq[0] : 0;
      total++; if (bus.out_valid !== (m_mq.size() > 0)) begin bad++;
        $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, bus.out_valid, m_mq.size() > 0); end
      total++; if (int'(bus.out_data) != exp_d) begin bad++;
        $display("FAIL rnd_data cyc=%0d got=%0d want=%0d", c, bus.out_data, exp_d); end
      total++; if (int'(bus.fifo_level) != m_mq.size()) begin bad++;
        $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", c, bus.fifo_level, m_mq.size()); end
      total++; if (int'(bus.dropped_count) != m_drops) begin bad++;
        $display("FAIL rnd_dropped cyc=%0d got=%0d want=%0d", c, bus.dropped_count, m_drops); end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    bus.out_ready = 1'b0;
    bus0.enable = 1'b0;
    bus0.adc_valid = 1'b0;
    bus0.adc_data = '0;
    bus0.out_ready = 1'b0;
    #1;
    test_reset();
    test_average();
    test_extremes();
    test_overflow();
    test_full_push_pop();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
